// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO and its read-side stream adapter.
// Buffer depth and occupancy type are used by fifo_rd_stream and stream_skid_buf.
package fifo_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int DEPTH_DEF    = 16;
    localparam int RD_BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry circular output buffer with occupancy count.
// Absorbs the word in flight from the FIFO RAM while downstream stalls.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output occ_t             occ
);

    logic [WIDTH-1:0] mem [RD_BUF_DEPTH];
    logic             wp;
    logic             rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            occ <= '0;
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            occ <= occ + occ_t'(push) - occ_t'(pop);
        end
    end

    assign dout = mem[rp];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter, one word per cycle.
// Optional delivered-word counter enabled by FIFO_RD_STAT_EN.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
`ifdef FIFO_RD_STAT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             rclk,
    input  logic             rrstn,
    input  logic             rempty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout_data
`ifdef FIFO_RD_STAT_EN
    ,
    output logic [CNT_W-1:0] word_cnt
`endif
);

    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] pending;

    assign pop        = dout_valid && dout_ready;
    assign dout_valid = (occ != '0);

    // Space is counted after this cycle's pop so a full buffer streams.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign rinc    = rrstn && !rempty && (pending < 3'(RD_BUF_DEPTH));

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rinc;
        end
    end

    stream_skid_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk  (rclk),
        .rst_n(rrstn),
        .push (inflight),
        .pop  (pop),
        .din  (rdata),
        .dout (dout_data),
        .occ  (occ)
    );

`ifdef FIFO_RD_STAT_EN
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream against a behavioural FIFO read port.
// Build with FIFO_RD_STAT_EN defined to also exercise word_cnt.
module tb_fifo_rd_stream;

    logic       rclk = 1'b0;
    logic       rrstn = 1'b0;
    logic       rempty = 1'b1;
    logic [7:0] rdata = '0;
    logic       rinc;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic [7:0] dout_data;
`ifdef FIFO_RD_STAT_EN
    logic [3:0] word_cnt;
`endif

    fifo_rd_stream #(
        .WIDTH(8)
`ifdef FIFO_RD_STAT_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .rclk      (rclk),
        .rrstn     (rrstn),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_data (dout_data)
`ifdef FIFO_RD_STAT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       hold_empty = 1'b0;
    logic [7:0] w;
    logic [7:0] w2;
    logic [7:0] last_data = '0;
    logic [7:0] prev_data = '0;
    logic       prev_hold = 1'b0;
    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int rinc_cnt = 0;
    int pop_cnt = 0;
    int first_pop = 0;
    int last_pop = 0;
    int outst = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: registered read, empty flag refreshed after each edge.
    always @(posedge rclk) begin
        cyc++;
        if (rinc && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            rdata <= w;
            exp_q.push_back(w);
        end
        #1 rempty = hold_empty || (fifo_q.size() == 0);
    end

    always @(negedge rrstn) exp_q.delete();

    // Monitor: scoreboard compare plus protocol invariants.
    always @(negedge rclk) begin
        if (!rrstn) begin
            outst = 0;
            prev_hold = 1'b0;
            check("rst_rinc", rinc, 0);
            check("rst_valid", dout_valid, 0);
        end else begin
            check("rinc_while_empty", rinc && rempty, 0);
            if (prev_hold) begin
                check("hold_valid", dout_valid, 1);
                check("hold_data", dout_data, prev_data);
            end
            if (rinc) rinc_cnt++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    w2 = exp_q.pop_front();
                    check("data", dout_data, w2);
                end
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                last_data = dout_data;
                pop_cnt++;
            end
            outst = outst + int'(rinc) - int'(dout_valid && dout_ready);
            check("occupancy", outst <= 2, 1);
            prev_hold = dout_valid && !dout_ready;
            prev_data = dout_data;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge rclk);
        #2;
    endtask

    task automatic load(logic [7:0] base, int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
    endtask

    task automatic clr();
        rinc_cnt = 0;
        pop_cnt = 0;
    endtask

    logic [39:0] pat = 40'hC3_1A_F0_25_9C;

    initial begin
        // 1: reset and first-word latency
        load(8'hA5, 1);
        step(3);
        rrstn = 1'b1;
        @(negedge rclk);
        check("t1_first_rinc", rinc, 1);
        check("t1_valid_c0", dout_valid, 0);
        @(negedge rclk);
        check("t1_valid_c1", dout_valid, 0);
        @(negedge rclk);
        check("t1_valid_c2", dout_valid, 1);
        check("t1_data", dout_data, 8'hA5);
        step(1);
        dout_ready = 1'b1;
        step(3);

        // 2: full-rate streaming
        clr();
        load(8'h01, 16);
        step(30);
        check("t2_rinc_cnt", rinc_cnt, 16);
        check("t2_pop_cnt", pop_cnt, 16);
        check("t2_no_gaps", last_pop - first_pop, 15);
        check("t2_last", last_data, 8'h10);

        // 3: backpressure
        dout_ready = 1'b0;
        clr();
        load(8'h20, 8);
        step(10);
        check("t3_rinc_stalled", rinc_cnt, 2);
        check("t3_no_pop", pop_cnt, 0);
        check("t3_valid", dout_valid, 1);
        check("t3_head", dout_data, 8'h20);
        dout_ready = 1'b1;
        step(15);
        check("t3_pop_cnt", pop_cnt, 8);
        check("t3_rinc_cnt", rinc_cnt, 8);
        check("t3_last", last_data, 8'h27);

        // 4: toggling ready with gated empty
        clr();
        load(8'h40, 12);
        for (int i = 0; i < 40; i++) begin
            dout_ready = (i % 2 == 0);
            hold_empty = pat[i];
            step(1);
        end
        hold_empty = 1'b0;
        dout_ready = 1'b1;
        step(15);
        check("t4_pop_cnt", pop_cnt, 12);
        check("t4_last", last_data, 8'h4B);
        check("t4_drained", exp_q.size(), 0);

        // 5: reset with a full buffer
        dout_ready = 1'b0;
        clr();
        load(8'h60, 3);
        step(8);
        check("t5_full_valid", dout_valid, 1);
        check("t5_rinc_cnt", rinc_cnt, 2);
        rrstn = 1'b0;
        #1;
        check("t5_async_valid", dout_valid, 0);
        check("t5_async_rinc", rinc, 0);
        step(2);
        rrstn = 1'b1;
        clr();
        dout_ready = 1'b1;
        step(10);
        check("t5_pop_cnt", pop_cnt, 1);
        check("t5_survivor", last_data, 8'h62);
        check("t5_fifo_empty", fifo_q.size(), 0);

`ifdef FIFO_RD_STAT_EN
        // 6: word counter and wrap
        rrstn = 1'b0;
        #1;
        check("t6_cnt_rst", word_cnt, 0);
        step(1);
        rrstn = 1'b1;
        clr();
        load(8'h80, 16);
        step(25);
        check("t6_pop16", pop_cnt, 16);
        check("t6_wrap", word_cnt, 0);
        load(8'h90, 4);
        step(10);
        check("t6_pop20", pop_cnt, 20);
        check("t6_cnt20", word_cnt, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
